// File: rtl/esc_pkg.sv
// ============================================================================
// esc_pkg : shared constants, width helpers and counter type for the ESC PWM
//           block (esc_interface_multi / esc_pwm_channel).
// Revision : 1.0
// ============================================================================
`default_nettype none

package esc_pkg;

  localparam int DEF_SPEED_W = 11;
  localparam int DEF_OFFSET  = 6250;
  localparam int DEF_SCALE   = 3;
  localparam int DEF_PERIOD  = 125000;

  // Pulse width in clocks for a given speed code.
  function automatic int unsigned pulse_width(
    input int unsigned spd,
    input int unsigned offset = DEF_OFFSET,
    input int unsigned scale  = DEF_SCALE
  );
    return offset + scale * spd;
  endfunction

  // Bits needed to hold the widest pulse without truncation.
  function automatic int cnt_width(
    input int unsigned offset,
    input int unsigned scale,
    input int          speed_w
  );
    return $clog2(pulse_width((2 ** speed_w) - 1, offset, scale) + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_OFFSET, DEF_SCALE, DEF_SPEED_W);

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/esc_pwm_channel.sv
// ============================================================================
// esc_pwm_channel : one ESC output - shadow speed register, optional clamp
//                   (ESC_CLAMP_EN), width down-counter and registered pwm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module esc_pwm_channel
  import esc_pkg::*;
#(
  parameter int          SPEED_W   = DEF_SPEED_W,
  parameter int          OFFSET    = DEF_OFFSET,
  parameter int          SCALE     = DEF_SCALE,
  parameter int unsigned MAX_SPEED = 2047,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load,
  input  logic [SPEED_W-1:0] speed_in,
  output logic               pwm
);

`ifdef ESC_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  localparam int unsigned FULL_SPEED = (2 ** SPEED_W) - 1;
  localparam int unsigned CEIL       = (MAX_SPEED < FULL_SPEED) ? MAX_SPEED : FULL_SPEED;
  localparam logic [SPEED_W-1:0] CEIL_V = SPEED_W'(CEIL);

  logic [SPEED_W-1:0] speed_sat;
  logic [SPEED_W-1:0] shadow_d, shadow_q;
  logic [CNT_W-1:0]   width;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               pwm_d, pwm_q;

  always_comb begin
    speed_sat = speed_in;
    if (CLAMP_ON && (speed_in > CEIL_V)) begin
      speed_sat = CEIL_V;
    end

    // A load on the start edge must already use the new speed.
    shadow_d = load ? speed_sat : shadow_q;
    width    = CNT_W'(pulse_width(32'(shadow_d), OFFSET, SCALE));

    cnt_d = cnt_q;
    pwm_d = pwm_q;
    if (start) begin
      pwm_d = (width != '0);
      cnt_d = (width != '0) ? (width - CNT_W'(1)) : '0;
    end else if (pwm_q) begin
      if (cnt_q == '0) begin
        pwm_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

`default_nettype wire

// File: rtl/esc_interface_multi.sv
// ============================================================================
// esc_interface_multi : NUM_CH ESC pulse generator, trigger or frame mode;
//                       optional speed clamp via ESC_CLAMP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module esc_interface_multi
  import esc_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          SPEED_W    = DEF_SPEED_W,
  parameter int          OFFSET     = DEF_OFFSET,
  parameter int          SCALE      = DEF_SCALE,
  parameter int          AUTO_FRAME = 0,
  parameter int          PERIOD     = DEF_PERIOD,
  parameter int unsigned MAX_SPEED  = 2047
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wrt,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start,
  output logic                      busy
);

  localparam int          CNT_W = cnt_width(OFFSET, SCALE, SPEED_W);
  localparam int unsigned MAX_W = pulse_width((2 ** SPEED_W) - 1, OFFSET, SCALE);

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("esc_interface_multi: NUM_CH must be at least 1");
  end
  if (SCALE < 1) begin : g_chk_scale
    $error("esc_interface_multi: SCALE must be at least 1");
  end
  if ((AUTO_FRAME != 0) && (PERIOD <= int'(MAX_W))) begin : g_chk_period
    $error("esc_interface_multi: PERIOD must exceed the widest pulse");
  end

  logic start;
  logic frame_start_d, frame_start_q;

  if (AUTO_FRAME != 0) begin : g_frame
    localparam int FRM_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [FRM_W-1:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
      frame_cnt_d = (frame_cnt_q == FRM_W'(PERIOD - 1)) ? '0 : (frame_cnt_q + FRM_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        frame_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_d;
      end
    end

    // Count resets to 0, so the first frame begins on the first edge after release.
    assign start = (frame_cnt_q == '0);
  end else begin : g_trigger
    assign start = wrt;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    esc_pwm_channel #(
      .SPEED_W   (SPEED_W),
      .OFFSET    (OFFSET),
      .SCALE     (SCALE),
      .MAX_SPEED (MAX_SPEED),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .load     (wrt),
      .speed_in (speed[i*SPEED_W +: SPEED_W]),
      .pwm      (pwm[i])
    );
  end

  always_comb begin
    frame_start_d = start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
  assign busy        = |pwm;

endmodule

`default_nettype wire

// File: tb/tb_esc_interface_multi.sv
// ============================================================================
// tb_esc_interface_multi : four configurations driven together; expected
//                          outputs come from per-channel fall-time bookkeeping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_esc_interface_multi;

  // d0 trigger/defaults, d1 frame PERIOD=20000, d2 small trigger, d3 small frame
  localparam int          NCH  [4] = '{4, 4, 3, 2};
  localparam int          OFF  [4] = '{6250, 6250, 5, 3};
  localparam int          SCL  [4] = '{3, 3, 2, 2};
  localparam bit          AUTO [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam int          PER  [4] = '{1, 20000, 1, 40};
  localparam int unsigned MAXS [4] = '{1000, 2047, 9, 7};

`ifdef ESC_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit          drv_wrt [4];
  int unsigned drv_spd [4][4];

  logic [43:0] spd_a, spd_f;
  logic [11:0] spd_s;
  logic [7:0]  spd_sf;
  logic [3:0]  pwm_a, pwm_f;
  logic [2:0]  pwm_s;
  logic [1:0]  pwm_sf;
  logic        fs_a, fs_f, fs_s, fs_sf;
  logic        busy_a, busy_f, busy_s, busy_sf;

  always_comb begin
    spd_a  = '0;
    spd_f  = '0;
    spd_s  = '0;
    spd_sf = '0;
    for (int i = 0; i < 4; i++) begin
      spd_a[i*11 +: 11] = drv_spd[0][i][10:0];
      spd_f[i*11 +: 11] = drv_spd[1][i][10:0];
    end
    for (int i = 0; i < 3; i++) spd_s[i*4 +: 4] = drv_spd[2][i][3:0];
    for (int i = 0; i < 2; i++) spd_sf[i*4 +: 4] = drv_spd[3][i][3:0];
  end

  esc_interface_multi #(.NUM_CH(4), .SPEED_W(11), .OFFSET(6250), .SCALE(3),
                        .AUTO_FRAME(0), .PERIOD(125000), .MAX_SPEED(1000)) u_a (
    .clk(clk), .rst_n(rst_n), .wrt(drv_wrt[0]), .speed(spd_a),
    .pwm(pwm_a), .frame_start(fs_a), .busy(busy_a));

  esc_interface_multi #(.NUM_CH(4), .SPEED_W(11), .OFFSET(6250), .SCALE(3),
                        .AUTO_FRAME(1), .PERIOD(20000), .MAX_SPEED(2047)) u_f (
    .clk(clk), .rst_n(rst_n), .wrt(drv_wrt[1]), .speed(spd_f),
    .pwm(pwm_f), .frame_start(fs_f), .busy(busy_f));

  esc_interface_multi #(.NUM_CH(3), .SPEED_W(4), .OFFSET(5), .SCALE(2),
                        .AUTO_FRAME(0), .PERIOD(100), .MAX_SPEED(9)) u_s (
    .clk(clk), .rst_n(rst_n), .wrt(drv_wrt[2]), .speed(spd_s),
    .pwm(pwm_s), .frame_start(fs_s), .busy(busy_s));

  esc_interface_multi #(.NUM_CH(2), .SPEED_W(4), .OFFSET(3), .SCALE(2),
                        .AUTO_FRAME(1), .PERIOD(40), .MAX_SPEED(7)) u_sf (
    .clk(clk), .rst_n(rst_n), .wrt(drv_wrt[3]), .speed(spd_sf),
    .pwm(pwm_sf), .frame_start(fs_sf), .busy(busy_sf));

  // Reference: a channel is high after edge e iff e < fall_e (start edge + width).
  longint      cyc;
  longint      fall_e [4][4];
  int unsigned shadow [4][4];
  bit          fs_exp [4];
  longint      base   [4];
  int          n_cmp;
  int          n_fail;

  function automatic int unsigned eff_speed(int d, int unsigned v);
    return (CLAMP_ON && (v > MAXS[d])) ? MAXS[d] : v;
  endfunction

  task automatic compare();
    logic [5:0] obs, exp;
    logic [3:0] pe;
    for (int d = 0; d < 4; d++) begin
      pe = '0;
      for (int c = 0; c < NCH[d]; c++) pe[c] = (cyc < fall_e[d][c]);
      exp = {pe, fs_exp[d], |pe};
      case (d)
        0:       obs = {pwm_a, fs_a, busy_a};
        1:       obs = {pwm_f, fs_f, busy_f};
        2:       obs = {1'b0, pwm_s, fs_s, busy_s};
        default: obs = {2'b00, pwm_sf, fs_sf, busy_sf};
      endcase
      n_cmp++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL dut%0d_pwm_fs_busy cyc=%0d observed=%b expected=%b", d, cyc, obs, exp);
      end
    end
  endtask

  task automatic tick();
    longint e;
    bit     st;
    e = cyc + 1;
    for (int d = 0; d < 4; d++) begin
      st = 1'b0;
      if (rst_n) begin
        if (drv_wrt[d]) begin
          for (int c = 0; c < NCH[d]; c++) shadow[d][c] = eff_speed(d, drv_spd[d][c]);
        end
        st = AUTO[d] ? (((e - base[d]) % longint'(PER[d])) == 0) : drv_wrt[d];
        if (st) begin
          for (int c = 0; c < NCH[d]; c++)
            fall_e[d][c] = e + longint'(OFF[d]) + longint'(SCL[d]) * longint'(shadow[d][c]);
        end
      end
      fs_exp[d] = st;
    end
    @(posedge clk);
    cyc = e;
    #1;
    compare();
  endtask

  // Background: random loads on the small configs, scheduled loads on d1.
  task automatic run(int n);
    longint fe;
    for (int k = 0; k < n; k++) begin
      fe = cyc + 1 - base[1];
      drv_wrt[1] = 1'b0;
      if (fe == 21000) begin
        drv_spd[1][0] = 32'h228;
        for (int c = 1; c < 4; c++) drv_spd[1][c] = 0;
        drv_wrt[1] = 1'b1;
      end else if (fe == 40500) begin
        for (int c = 0; c < 4; c++) drv_spd[1][c] = $urandom_range(0, 2047);
        drv_wrt[1] = 1'b1;
      end else if (fe == 60000) begin
        drv_spd[1][0] = 0;
        drv_spd[1][1] = 32'h7FF;
        drv_spd[1][2] = $urandom_range(0, 2047);
        drv_spd[1][3] = 5;
        drv_wrt[1] = 1'b1;
      end
      drv_wrt[2] = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < 3; c++) drv_spd[2][c] = $urandom_range(0, 15);
      drv_wrt[3] = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < 2; c++) drv_spd[3][c] = $urandom_range(0, 15);
      tick();
    end
  endtask

  task automatic set_a(int unsigned s0, int unsigned s1, int unsigned s2, int unsigned s3);
    drv_spd[0][0] = s0;
    drv_spd[0][1] = s1;
    drv_spd[0][2] = s2;
    drv_spd[0][3] = s3;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 4; d++) begin
      drv_wrt[d] = 1'b0;
      fs_exp[d]  = 1'b0;
      base[d]    = 0;
      for (int c = 0; c < 4; c++) begin
        drv_spd[d][c] = 0;
        fall_e[d][c]  = 0;
        shadow[d][c]  = 0;
      end
    end

    // Reset state, then release away from the clock edge.
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) base[d] = cyc + 1;
    run(10);

    // All speeds zero: OFFSET-wide pulses.
    set_a(0, 0, 0, 0);
    drv_wrt[0] = 1'b1; run(1); drv_wrt[0] = 1'b0;
    run(6300);

    // Mixed speeds including full scale.
    set_a(32'h000, 32'h228, 32'h7FF, 32'h100);
    drv_wrt[0] = 1'b1; run(1); drv_wrt[0] = 1'b0;
    run(12400);

    // Retrigger 3000 edges into a pulse.
    set_a(0, 0, 0, 0);
    drv_wrt[0] = 1'b1; run(1); drv_wrt[0] = 1'b0;
    run(2999);
    set_a(32'h7FF, 0, 0, 0);
    drv_wrt[0] = 1'b1; run(1); drv_wrt[0] = 1'b0;
    run(12400);

    // Held wrt with changing random speeds.
    repeat (2) begin
      drv_wrt[0] = 1'b1;
      repeat ($urandom_range(2, 5)) begin
        set_a($urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047), $urandom_range(0, 2047));
        run(1);
      end
      drv_wrt[0] = 1'b0;
      run(12400);
    end

    // Let the frame-mode schedule play out.
    while (cyc < 73000) run(1);

    // Reset 4000 edges into a 7906-wide pulse.
    set_a(32'h228, 32'h228, 32'h228, 32'h228);
    drv_wrt[0] = 1'b1; run(1); drv_wrt[0] = 1'b0;
    run(3999);
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      fs_exp[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        fall_e[d][c] = 0;
        shadow[d][c] = 0;
      end
    end
    #1;
    compare();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) base[d] = cyc + 1;
    run(7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
